// File: rtl/strb_period_checker.sv
// Measures the interval between rising edges of a same-domain strobe.
// Reports lock against the expected period, and flags deviations and strobe loss.
module strb_period_checker #(
  parameter int CNT_W   = 16,
  parameter int EXPECT  = 8,
  parameter int TOL     = 0,
  parameter int TIMEOUT = 1023,
  parameter int LOCK_N  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             strb_in,
  input  logic             err_clr,
  output logic [CNT_W-1:0] period,
  output logic             period_vld,
  output logic             locked,
  output logic             err,
  output logic             timeout,
  output logic [7:0]       edge_cnt
);

  localparam int GW = $clog2(LOCK_N + 1);
  localparam logic [GW-1:0]    LOCK_MAX = GW'(LOCK_N);
  localparam logic [CNT_W-1:0] TO_VAL   = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  // Lower bound clamps at zero so a large TOL cannot wrap around.
  localparam int unsigned LO_BOUND = (EXPECT > TOL) ? (EXPECT - TOL) : 0;
  localparam int unsigned HI_BOUND = EXPECT + TOL;

  typedef enum logic [1:0] {IDLE, ARM, MEAS} state_t;

  state_t           state_q, state_d;
  logic             strb_d_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             period_vld_q, period_vld_d;
  logic             locked_q, locked_d;
  logic             err_q, err_d;
  logic             timeout_q, timeout_d;
  logic [7:0]       edge_cnt_q, edge_cnt_d;
  logic [GW-1:0]    good_q, good_d;
  logic             rise;
  logic             in_range;
  logic             err_set;

  assign rise     = strb_in & ~strb_d_q;
  assign in_range = (32'(cnt_q) >= LO_BOUND) && (32'(cnt_q) <= HI_BOUND);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    period_d     = period_q;
    period_vld_d = 1'b0;
    locked_d     = locked_q;
    timeout_d    = 1'b0;
    good_d       = good_q;
    edge_cnt_d   = edge_cnt_q;
    err_set      = 1'b0;

    if (rise && en && (state_q != IDLE)) begin
      edge_cnt_d = edge_cnt_q + 8'd1;
    end

    if (!en) begin
      // Dropping enable discards any partial interval.
      state_d  = IDLE;
      cnt_d    = '0;
      locked_d = 1'b0;
      good_d   = '0;
    end else begin
      case (state_q)
        IDLE: state_d = ARM;
        ARM: begin
          if (rise) begin
            cnt_d   = CNT_W'(1);
            state_d = MEAS;
          end
        end
        MEAS: begin
          if (rise) begin
            period_d     = cnt_q;
            period_vld_d = 1'b1;
            cnt_d        = CNT_W'(1);
            if (in_range) begin
              good_d = (good_q == LOCK_MAX) ? good_q : good_q + GW'(1);
              if (good_d == LOCK_MAX) begin
                locked_d = 1'b1;
              end
            end else begin
              good_d   = '0;
              locked_d = 1'b0;
              err_set  = locked_q;
            end
          end else if (cnt_q == TO_VAL) begin
            timeout_d = 1'b1;
            err_set   = 1'b1;
            locked_d  = 1'b0;
            good_d    = '0;
            cnt_d     = '0;
            state_d   = ARM;
          end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // A new error outranks a simultaneous clear request.
    if (err_set) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      strb_d_q     <= 1'b0;
      cnt_q        <= '0;
      period_q     <= '0;
      period_vld_q <= 1'b0;
      locked_q     <= 1'b0;
      err_q        <= 1'b0;
      timeout_q    <= 1'b0;
      edge_cnt_q   <= 8'd0;
      good_q       <= '0;
    end else begin
      state_q      <= state_d;
      strb_d_q     <= strb_in;
      cnt_q        <= cnt_d;
      period_q     <= period_d;
      period_vld_q <= period_vld_d;
      locked_q     <= locked_d;
      err_q        <= err_d;
      timeout_q    <= timeout_d;
      edge_cnt_q   <= edge_cnt_d;
      good_q       <= good_d;
    end
  end

  assign period     = period_q;
  assign period_vld = period_vld_q;
  assign locked     = locked_q;
  assign err        = err_q;
  assign timeout    = timeout_q;
  assign edge_cnt   = edge_cnt_q;

endmodule

// File: tb/tb_strb_period_checker.sv
// Randomised bench for strb_period_checker: a timestamp-based reference model
// queues the expected outputs of every cycle, and a monitor pops and compares them.
module tb_strb_period_checker;

  localparam int CNT_W   = 16;
  localparam int EXPECT  = 8;
  localparam int TOL     = 0;
  localparam int TIMEOUT = 1023;
  localparam int LOCK_N  = 2;

  logic             clk;
  logic             rst;
  logic             en;
  logic             strb_in;
  logic             err_clr;
  logic [CNT_W-1:0] period;
  logic             period_vld;
  logic             locked;
  logic             err;
  logic             timeout;
  logic [7:0]       edge_cnt;

  strb_period_checker #(
    .CNT_W(CNT_W), .EXPECT(EXPECT), .TOL(TOL), .TIMEOUT(TIMEOUT), .LOCK_N(LOCK_N)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .strb_in(strb_in), .err_clr(err_clr),
    .period(period), .period_vld(period_vld), .locked(locked), .err(err),
    .timeout(timeout), .edge_cnt(edge_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic        tmo;
    int          per;
    logic        lck;
    logic        er;
    logic [7:0]  edges;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_mis = 0;

  // Reference model: remembers the cycle stamp of the last edge instead of counting.
  int unsigned lo_bound = (EXPECT > TOL) ? EXPECT - TOL : 0;
  int unsigned hi_bound = EXPECT + TOL;
  longint      cyc = 0;
  longint      m_last = 0;
  longint      interval;
  int          m_mode = 0;   // 0 disabled, 1 waiting for first edge, 2 measuring
  bit          m_prev = 0;
  bit          m_rise;
  bit          m_err_set;
  int          m_period = 0;
  int          m_good = 0;
  bit          m_locked = 0;
  bit          m_err = 0;
  logic [7:0]  m_edges = 8'd0;

  always @(posedge clk) begin
    exp_t e;
    cyc++;
    e.vld = 1'b0;
    e.tmo = 1'b0;
    m_rise = strb_in && !m_prev;
    if (!rst) begin
      m_mode = 0; m_prev = 0; m_period = 0; m_good = 0;
      m_locked = 0; m_err = 0; m_edges = 8'd0;
    end else begin
      m_err_set = 0;
      if (m_rise && en && m_mode != 0) m_edges = m_edges + 8'd1;
      if (!en) begin
        m_mode = 0; m_locked = 0; m_good = 0;
      end else if (m_mode == 0) begin
        m_mode = 1;
      end else if (m_mode == 1) begin
        if (m_rise) begin m_mode = 2; m_last = cyc; end
      end else begin
        interval = cyc - m_last;
        if (m_rise) begin
          m_period = (interval > 65535) ? 65535 : int'(interval);
          e.vld = 1'b1;
          if (m_period >= lo_bound && m_period <= hi_bound) begin
            if (m_good < LOCK_N) m_good++;
            if (m_good >= LOCK_N) m_locked = 1;
          end else begin
            if (m_locked) m_err_set = 1;
            m_good = 0; m_locked = 0;
          end
          m_last = cyc;
        end else if (interval == TIMEOUT) begin
          e.tmo = 1'b1; m_err_set = 1; m_locked = 0; m_good = 0; m_mode = 1;
        end
      end
      if (m_err_set) m_err = 1;
      else if (err_clr) m_err = 0;
      m_prev = strb_in;
    end
    e.per = m_period; e.lck = m_locked; e.er = m_err; e.edges = m_edges;
    sb_q.push_back(e);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("period_vld", 32'(period_vld), 32'(e.vld));
      chk("period",     32'(period),     32'(e.per));
      chk("locked",     32'(locked),     32'(e.lck));
      chk("err",        32'(err),        32'(e.er));
      chk("timeout",    32'(timeout),    32'(e.tmo));
      chk("edge_cnt",   32'(edge_cnt),   32'(e.edges));
    end
  end

  task automatic cycle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic strobe_period(input int n);
    strb_in = 1'b1;
    cycle(1);
    strb_in = 1'b0;
    if (n > 1) cycle(n - 1);
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    cycle(1);
    err_clr = 1'b0;
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    rst = 1'b0; en = 1'b1; strb_in = 1'b0; err_clr = 1'b0;
    cycle(3);
    rst = 1'b1;
    cycle(1100);                         // armed with no strobe: must stay quiet
    repeat (6) strobe_period(8);         // lock at 8
    strobe_period(10);                   // deviation while locked
    repeat (3) strobe_period(8);         // relock
    cycle(2);
    clear_err();
    repeat (3) strobe_period(8);
    cycle(1100);                         // strobe loss
    repeat (4) strobe_period(8);
    strb_in = 1'b1; cycle(20); strb_in = 1'b0; cycle(5);
    repeat (3) strobe_period(8);
    strb_in = 1'b1; cycle(1); strb_in = 1'b0; cycle(4);
    en = 1'b0; cycle(3); en = 1'b1; cycle(2);
    repeat (4) strobe_period(8);
    for (int i = 0; i < 250; i++) begin
      r = $urandom_range(0, 99);
      if (r < 55)      strobe_period(8);
      else if (r < 72) strobe_period($urandom_range(2, 20));
      else if (r < 80) begin
        strb_in = 1'b1; cycle($urandom_range(1, 12)); strb_in = 1'b0; cycle($urandom_range(1, 8));
      end
      else if (r < 87) clear_err();
      else if (r < 93) begin
        strb_in = 1'($urandom_range(0, 1));
        err_clr = 1'($urandom_range(0, 1));
        cycle(1);
        err_clr = 1'b0; strb_in = 1'b0;
      end
      else if (r < 98) begin
        en = 1'b0; cycle($urandom_range(1, 4)); en = 1'b1;
      end
      else cycle($urandom_range(1020, 1030));
    end
    repeat (4) strobe_period(8);
    strb_in = 1'b1; cycle(1); strb_in = 1'b0; cycle(3);
    rst = 1'b0; cycle(1); rst = 1'b1;
    cycle(5);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/strb_period_checker.md
Name: strb_period_checker

Overview:
- Receive-side companion to the prescaled counter strobe generator.
- Consumes a single-cycle strobe in the same clock domain and measures the interval between consecutive rising edges in clock cycles.
- Declares lock when the interval matches the expected prescaler period; flags deviations and strobe loss (timeout).
- Used as an on-chip monitor of prescaler/strobe health and as a self-check block in the counter subsystem.

Parameters:
CNT_W, 16, width of the interval counter and the period output
EXPECT, 8, expected strobe period in clk cycles (matches the generator PRESCALER); 1 <= EXPECT < TIMEOUT
TOL, 0, allowed +/- deviation from EXPECT, in cycles
TIMEOUT, 1023, cycles without a rising edge before strobe loss is declared; TIMEOUT < 2^CNT_W
LOCK_N, 2, number of consecutive in-tolerance periods required to assert locked; LOCK_N >= 1

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous reset, active-low (rst=0 resets on next clk edge)
en  in  1  measurement enable
strb_in  in  1  strobe from the generator; synchronous to clk, no synchroniser
err_clr  in  1  clears the sticky err
period  out  CNT_W  last measured interval in clk cycles
period_vld  out  1  one-cycle pulse when period updates
locked  out  1  strobe period stable within tolerance
err  out  1  sticky error: out-of-tolerance period while locked, or timeout
timeout  out  1  one-cycle pulse on strobe-loss detection
edge_cnt  out  8  free-running count of rising edges seen while en=1; wraps 255->0

Behaviour:
- Reset (rst=0 at a clk edge): state=IDLE. Interval counter, period, period_vld, locked, err, timeout, edge_cnt, the strb_in delay register and the good-period counter all go to 0. Reset wins over every other input.
- Edge detect: rise = strb_in & ~strb_d, where strb_d is strb_in registered. A level held high produces exactly one rise.
- FSM:
  - IDLE: entered whenever en=0, from any state, on the next edge. The counter clears, locked=0 and the good-period count=0. period and err hold their values. With en=1 the FSM goes to ARM.
  - ARM: waits for the first rise. On rise: cnt<=1, go to MEAS, no period_vld. If TIMEOUT cycles elapse in ARM without a rise, nothing happens.
  - MEAS, no rise: cnt<=cnt+1, saturating at 2^CNT_W-1.
  - MEAS, rise: period<=cnt and period_vld=1 on the following cycle (latency 1 clk after the rising strb_in is sampled); cnt<=1.
  - MEAS, timeout: if cnt reaches TIMEOUT with no rise on that cycle, timeout pulses for one cycle, err<=1, locked<=0, good count<=0, go to ARM. A rise on the same cycle as cnt==TIMEOUT counts as a measurement, not a timeout.
- Resulting measurement: a strobe with a rise every N cycles gives period=N.
- Tolerance check on each new period: in-range iff EXPECT-TOL <= period <= EXPECT+TOL. Unsigned comparison; the lower bound clamps at 0.
  - In-range: good count increments, saturating at LOCK_N. locked<=1 in the same cycle period_vld asserts once the count reaches LOCK_N.
  - Out-of-range: good count<=0 and locked<=0. If locked was 1, err<=1.
- err is sticky and clears only on err_clr=1 or reset. If err_clr and a set condition occur in the same cycle, set wins.
- edge_cnt increments on each rise while en=1, in every state except IDLE. It is not cleared by en; it is cleared only by reset.
- en deasserted mid-measurement: the partial interval is discarded and no period_vld is issued.

Test Plan:
- Reset with rst=0 for 3 clks, en=1, strb_in=0 -> all outputs 0, FSM in ARM, no timeout while in ARM.
- EXPECT=8, TOL=0, LOCK_N=2; 1-cycle strobe every 8 clks -> first rise gives no period_vld; then period=8 on every period_vld; locked=1 with the 2nd period_vld; err=0; edge_cnt increments once per strobe.
- While locked, one interval of 10 clks -> period=10, locked drops to 0 with that period_vld, err=1; two further 8-cycle periods relock. err stays 1 until err_clr=1 for 1 clk, then reads 0.
- Strobe stopped after lock, TIMEOUT=1023 -> exactly 1023 clks after the last rise, timeout pulses for 1 cycle, err=1, locked=0, FSM back in ARM. Next rise restarts measurement with no period_vld.
- strb_in held high for 20 clks, then low -> only one rise counted (edge_cnt +1). en=0 mid-interval -> no period_vld, locked=0, period holds its last value.
- rst=0 asserted while locked and mid-interval -> next cycle all outputs 0, including edge_cnt and err.
